tt_sweeper: RTL and testbench

TT_SWEEPER -- requirements
Module: tt_sweeper

---
 rtl/tt_pkg.sv | 14 +
 rtl/tt_sweeper.sv | 102 ++++++++++
 tb/tb_tt_sweeper.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweeper: controller states and
// the number of input vectors a three-input block exposes.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int VEC_COUNT = 8;
  localparam int IDX_W     = $clog2(VEC_COUNT);

endpackage

// File: rtl/tt_sweeper.sv
// Drives all eight {a,b,c} input combinations into a three-input block, holds
// each for DWELL cycles, then compares the x/y responses against expected tables.
module tt_sweeper
  import tt_pkg::*;
#(
  parameter int unsigned DWELL = 20,
  parameter logic [7:0]  EXP_X = 8'h96,
  parameter logic [7:0]  EXP_Y = 8'hE8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       x,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail_idx
);

  localparam int             CNT_W    = $clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_COUNT - 1);

  if (DWELL < 2 || DWELL > 255) begin : g_bad_dwell
    $error("tt_sweeper: DWELL must be in 2..255");
  end

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;

  // Either output differing makes the whole vector a single mismatch.
  assign mismatch = (x != EXP_X[idx]) || (y != EXP_Y[idx]);

  // idx is a flop and already reads 0 in IDLE and 7 in DONE, so it doubles
  // as the registered stimulus without a separate copy.
  assign {a, b, c} = idx;
  assign pass      = done && (err_count == 4'd0);

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // pre-edge values; blocking would make err_count see this edge's idx update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= 4'd0;
      first_fail_idx <= 3'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= RUN;
            idx            <= '0;
            cnt            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            err_count      <= 4'd0;
            first_fail_idx <= 3'd0;
          end
        end

        RUN: begin
          if (cnt == CNT_LAST) begin
            if (mismatch) begin
              // At most eight vectors per sweep, so four bits never wrap.
              err_count <= err_count + 4'd1;
              if (err_count == 4'd0) first_fail_idx <= idx;
            end
            if (idx == IDX_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
              cnt <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          idx   <= '0;
          cnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweeper.sv
// Self-checking bench for tt_sweeper: a sweep-level model checked every cycle,
// plus directed sweeps against clean and faulty three-input responders.
module tb_tt_sweeper;

  localparam int unsigned DWELL = 4;
  localparam logic [7:0]  EXP_X = 8'h96;
  localparam logic [7:0]  EXP_Y = 8'hE8;
  localparam int          SWEEP = 8 * DWELL;

  // Responder modes: 0 clean, 1 x stuck at 0, 2 y inverted, 3 x wrong at 111.
  localparam logic [1:0] M_CLEAN = 2'd0;
  localparam logic [1:0] M_STUCK = 2'd1;
  localparam logic [1:0] M_YINV  = 2'd2;
  localparam logic [1:0] M_LAST  = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       a, b, c;
  logic       x, y;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_fail_idx;
  logic [1:0] mode;

  int n_checks = 0;
  int n_errors = 0;

  tt_sweeper #(
    .DWELL(DWELL),
    .EXP_X(EXP_X),
    .EXP_Y(EXP_Y)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .a             (a),
    .b             (b),
    .c             (c),
    .x             (x),
    .y             (y),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_fail_idx(first_fail_idx)
  );

  always #5 clk = ~clk;

  function automatic logic resp_x(input logic [1:0] md, input int i);
    logic [2:0] v;
    logic       r;
    v = 3'(i);
    r = ^v;
    if (md == M_STUCK) r = 1'b0;
    if (md == M_LAST && i == 7) r = ~r;
    return r;
  endfunction

  function automatic logic resp_y(input logic [1:0] md, input int i);
    logic [2:0] v;
    logic       r;
    v = 3'(i);
    r = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    if (md == M_YINV) r = ~r;
    return r;
  endfunction

  always_comb begin
    x = resp_x(mode, int'({a, b, c}));
    y = resp_y(mode, int'({a, b, c}));
  end

  function automatic bit vec_bad(input logic [1:0] md, input int i);
    return (resp_x(md, i) != EXP_X[i]) || (resp_y(md, i) != EXP_Y[i]);
  endfunction

  function automatic int model_errs(input logic [1:0] md, input int sampled);
    int n = 0;
    for (int i = 0; i < sampled; i++) if (vec_bad(md, i)) n++;
    return n;
  endfunction

  function automatic int model_first(input logic [1:0] md, input int sampled);
    for (int i = 0; i < sampled; i++) if (vec_bad(md, i)) return i;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Sweep-level model: only tracks elapsed cycles since the start edge.
  bit         m_active;
  bit         m_done;
  int         m_n;
  logic [1:0] m_mode;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_n      <= 0;
      m_mode   <= M_CLEAN;
    end else if (m_active) begin
      m_n <= m_n + 1;
      if (m_n + 1 == SWEEP) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end
    end else if (start) begin
      m_active <= 1'b1;
      m_done   <= 1'b0;
      m_n      <= 0;
      m_mode   <= mode;
    end
  end

  always @(negedge clk) begin
    int sampled;
    int e_idx;
    int e_err;
    sampled = m_active ? m_n / DWELL : (m_done ? 8 : 0);
    e_idx   = m_active ? m_n / DWELL : (m_done ? 7 : 0);
    e_err   = model_errs(m_mode, sampled);
    check("cmp_abc",  {29'd0, a, b, c}, e_idx);
    check("cmp_busy", busy, m_active);
    check("cmp_done", done, m_done);
    check("cmp_errs", err_count, e_err);
    check("cmp_pass", pass, m_done && e_err == 0);
    if (e_err != 0) check("cmp_first", first_fail_idx, model_first(m_mode, sampled));
  end

  // Starts a sweep, optionally holding start high, and measures done latency.
  task automatic run_sweep(input logic [1:0] md, input bit hold,
                           output int lat, output int prev_err);
    @(negedge clk);
    mode  = md;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    lat      = 0;
    prev_err = err_count;
    while (!done && lat < 1000) begin
      prev_err = err_count;
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check("sweep_done_seen", done, 1);
    check("sweep_latency", lat, SWEEP);
  endtask

  initial begin
    int lat;
    int prev;
    int guard;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = M_CLEAN;
    repeat (3) @(negedge clk);
    check("reset_abc",   {a, b, c}, 0);
    check("reset_busy",  busy, 0);
    check("reset_done",  done, 0);
    check("reset_pass",  pass, 0);
    check("reset_errs",  err_count, 0);
    check("reset_first", first_fail_idx, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_holds", busy, 0);

    // Clean sweep with a start pulse.
    run_sweep(M_CLEAN, 1'b0, lat, prev);
    check("clean_errs", err_count, 0);
    check("clean_pass", pass, 1);
    check("clean_abc",  {a, b, c}, 7);

    // x stuck low: vectors 1,2,4,7 fail.
    run_sweep(M_STUCK, 1'b0, lat, prev);
    check("stuck_errs",  err_count, 4);
    check("stuck_first", first_fail_idx, 1);
    check("stuck_pass",  pass, 0);

    // start held high for the whole run must not disturb the sequence.
    run_sweep(M_CLEAN, 1'b1, lat, prev);
    check("hold_pass", pass, 1);
    repeat (3) @(negedge clk);
    check("hold_stays_done", done, 1);

    // Reset while vector 3 is driven, with two mismatches already counted.
    @(negedge clk);
    mode  = M_STUCK;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while ({a, b, c} != 3'd3 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("midreset_at_idx3", {a, b, c}, 3);
    check("midreset_errs_before", err_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_abc",   {a, b, c}, 0);
    check("midreset_busy",  busy, 0);
    check("midreset_errs",  err_count, 0);
    check("midreset_first", first_fail_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midreset_idle", busy, 0);
    run_sweep(M_CLEAN, 1'b0, lat, prev);
    check("after_reset_pass", pass, 1);

    // Restart from DONE: all-fail sweep then a clean one.
    run_sweep(M_YINV, 1'b0, lat, prev);
    check("yinv_errs",  err_count, 8);
    check("yinv_first", first_fail_idx, 0);
    check("yinv_pass",  pass, 0);
    run_sweep(M_CLEAN, 1'b0, lat, prev);
    check("restart_errs",  err_count, 0);
    check("restart_pass",  pass, 1);
    check("restart_first", first_fail_idx, 0);

    // Only vector 7 fails; the count must appear on the done edge itself.
    run_sweep(M_LAST, 1'b0, lat, prev);
    check("last_errs_before_done", prev, 0);
    check("last_errs",  err_count, 1);
    check("last_first", first_fail_idx, 7);
    check("last_pass",  pass, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
